arbitro_memoria: RTL and testbench
==================================

Name: arbitro_memoria

Overview:
- Sits directly upstream of the shared instruction/data memory in the MIPS CPU.
- Arbitrates between the instruction-fetch port (IF) and the data-memory port (MEM stage), both of which request a single shared memory.
- Drives the memory's address, write data, instruction/data select, read strobe and write strobe.
- Captures the memory's read word and returns it to the granted requester with a one-cycle ready pulse.

Parameters:
- MEM_LAT, 1, number of cycles the memory signals are held stable before the output is sampled (1..7).
- MAX_STREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced to win.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request; held until if_ready.
- if_addr  input  32  fetch byte address.
- if_ready  output  1  one-cycle pulse: if_instr valid.
- if_instr  output  32  fetched instruction word.
- if_err  output  1  valid with if_ready: address misaligned or out of range.
- dm_req  input  1  data request; held until dm_ready.
- dm_we  input  1  1 = write, 0 = read.
- dm_addr  input  32  data byte address.
- dm_wdata  input  32  write data.
- dm_ready  output  1  one-cycle pulse: access complete.
- dm_rdata  output  32  read data (0 for writes).
- dm_err  output  1  valid with dm_ready: address misaligned or out of range.
- mem_endereco  output  32  word index to memory.
- mem_indata  output  32  write data to memory.
- mem_controle  output  1  1 = data array, 0 = instruction array.
- mem_lerMem  output  1  read strobe.
- mem_escMem  output  1  write strobe.
- mem_output  input  32  memory read word.

Behaviour:
- Clocking: one clock, synchronous active-high reset.
- Reset values: state = IDLE, streak = 0. All outputs are 0: ready, err, data and all mem_* signals.
- States:
  - IDLE: arbitrate.
  - ACCESS: drive memory; count runs 1..MEM_LAT.
  - DONE: pulse ready; then return to IDLE.
- Arbitration in IDLE:
  - Only one request: grant it.
  - Both requests: data wins unless streak == MAX_STREAK, in which case fetch wins.
  - streak increments on each data grant made while if_req=1, saturating at MAX_STREAK.
  - streak clears on any fetch grant, or on any grant made while if_req=0.
- Address check at grant:
  - Error if addr[1:0] != 0 or addr[31:11] != 0.
  - On error: go IDLE -> DONE directly, with no memory access. Ready = 1, err = 1, data = 0.
  - Otherwise: latch the granted request's signals (write flag, word index, write data) and go to ACCESS.
- ACCESS:
  - mem_endereco = {23'b0, addr[10:2]} (word index 0..511).
  - mem_controle = 1 for data, 0 for fetch.
  - Data read: mem_lerMem = 1. Data write: mem_escMem = 1 and mem_indata = wdata. Fetch: both strobes = 0.
  - All mem_* signals are held stable for exactly MEM_LAT cycles.
  - On the last ACCESS cycle, mem_output is registered into the response register (data reads and fetches only). Then go to DONE.
- DONE: the granted port's ready is 1 for exactly one cycle; data and err are valid in that cycle. All mem_* signals = 0 in DONE and in IDLE.
- Latency: grant at cycle T gives ready at cycle T+MEM_LAT+1. A misaligned or out-of-range access gives ready at T+1.
- Request lifetime:
  - Latched operands are used once granted; changes on the request inputs after grant are ignored.
  - If req is dropped mid-transaction, the transaction still completes and ready still pulses.
- Back-to-back: a req still high at DONE is re-arbitrated in the following IDLE cycle. There is no accept in DONE.
- if_* and dm_* response registers hold their last values between pulses; only the ready pulses are one cycle.
- Reset asserted in any state: the next state is IDLE, all outputs go to 0, and the in-flight access is abandoned with no ready pulse.

Test Plan:
- Fetch only, MEM_LAT=1: if_addr=0x10 at T, memory word 4 = 0x2002_0005.
  - Required: mem_endereco=4 and mem_controle=0 at T+1; if_ready=1 and if_instr=0x2002_0005 at T+2; mem_* = 0 at T+2.
- Data write then read of the same address: dm_we=1, dm_addr=0x20, dm_wdata=0xDEAD_BEEF.
  - Required: mem_escMem=1, mem_controle=1, mem_endereco=8 for one cycle; dm_ready pulses.
  - Then a read of 0x20 returns dm_rdata=0xDEAD_BEEF, with mem_lerMem=1 and mem_escMem=0.
- Simultaneous if_req and dm_req held continuously, MAX_STREAK=4.
  - Required grant order: D, D, D, D, I, D, D, D, D, I; no port gets two ready pulses in the same cycle.
- Error paths:
  - dm_addr=0x22 -> dm_ready one cycle after grant, dm_err=1, dm_rdata=0, no mem strobe seen.
  - if_addr=0x800 -> if_err=1.
- Reset and latency:
  - With MEM_LAT=3, reset asserted in the 2nd ACCESS cycle -> next cycle all outputs 0, no dm_ready; a new request afterwards completes normally.
  - MEM_LAT=3 latency check: ready exactly 4 cycles after grant, with mem signals held constant for 3 cycles.

Source files
------------

// File: rtl/arbitro_memoria.sv
// Shared instruction/data memory arbiter for the MIPS core: grants IF or MEM,
// drives the memory for MEM_LAT cycles, then returns the word with a one-cycle ready.
module arbitro_memoria #(
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_instr,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic [31:0] mem_endereco,
    output logic [31:0] mem_indata,
    output logic        mem_controle,
    output logic        mem_lerMem,
    output logic        mem_escMem,
    input  logic [31:0] mem_output
);
    localparam int              SW         = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [2:0]      LAT        = 3'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [2:0]    count_q, count_d;
    logic          if_ready_q, if_ready_d;
    logic [31:0]   if_instr_q, if_instr_d;
    logic          if_err_q, if_err_d;
    logic          dm_ready_q, dm_ready_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          dm_err_q, dm_err_d;
    logic [31:0]   mem_endereco_q, mem_endereco_d;
    logic [31:0]   mem_indata_q, mem_indata_d;
    logic          mem_controle_q, mem_controle_d;
    logic          mem_lerMem_q, mem_lerMem_d;
    logic          mem_escMem_q, mem_escMem_d;

    logic          pick_data;
    logic [31:0]   sel_addr;
    logic          addr_bad;

    // Data wins a tie until it has taken MAX_STREAK grants in a row over a waiting fetch.
    assign pick_data = dm_req && (!if_req || (streak_q != STREAK_MAX));
    assign sel_addr  = pick_data ? dm_addr : if_addr;
    assign addr_bad  = (sel_addr[1:0] != 2'b00) || (sel_addr[31:11] != 21'b0);

    always_comb begin
        // NOTE: every _d starts from its _q (or a zero pulse) so no path leaves a latch.
        state_d        = state_q;
        streak_d       = streak_q;
        count_d        = count_q;
        if_ready_d     = 1'b0;
        if_instr_d     = if_instr_q;
        if_err_d       = if_err_q;
        dm_ready_d     = 1'b0;
        dm_rdata_d     = dm_rdata_q;
        dm_err_d       = dm_err_q;
        mem_endereco_d = mem_endereco_q;
        mem_indata_d   = mem_indata_q;
        mem_controle_d = mem_controle_q;
        mem_lerMem_d   = mem_lerMem_q;
        mem_escMem_d   = mem_escMem_q;

        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    // A data grant with if_req high implies streak_q < STREAK_MAX, so no wrap.
                    streak_d = (pick_data && if_req) ? streak_q + 1'b1 : '0;
                    if (addr_bad) begin
                        state_d = DONE;
                        if (pick_data) begin
                            dm_ready_d = 1'b1;
                            dm_err_d   = 1'b1;
                            dm_rdata_d = '0;
                        end else begin
                            if_ready_d = 1'b1;
                            if_err_d   = 1'b1;
                            if_instr_d = '0;
                        end
                    end else begin
                        state_d        = ACCESS;
                        count_d        = 3'd1;
                        mem_endereco_d = {23'b0, sel_addr[10:2]};
                        mem_controle_d = pick_data;
                        mem_lerMem_d   = pick_data && !dm_we;
                        mem_escMem_d   = pick_data && dm_we;
                        mem_indata_d   = (pick_data && dm_we) ? dm_wdata : '0;
                    end
                end
            end
            ACCESS: begin
                if (count_q == LAT) begin
                    state_d        = DONE;
                    mem_endereco_d = '0;
                    mem_indata_d   = '0;
                    mem_controle_d = 1'b0;
                    mem_lerMem_d   = 1'b0;
                    mem_escMem_d   = 1'b0;
                    if (mem_controle_q) begin
                        dm_ready_d = 1'b1;
                        dm_err_d   = 1'b0;
                        dm_rdata_d = mem_escMem_q ? '0 : mem_output;
                    end else begin
                        if_ready_d = 1'b1;
                        if_err_d   = 1'b0;
                        if_instr_d = mem_output;
                    end
                end else begin
                    count_d = count_q + 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
        if (reset) begin
            state_q        <= IDLE;
            streak_q       <= '0;
            count_q        <= '0;
            if_ready_q     <= 1'b0;
            if_instr_q     <= '0;
            if_err_q       <= 1'b0;
            dm_ready_q     <= 1'b0;
            dm_rdata_q     <= '0;
            dm_err_q       <= 1'b0;
            mem_endereco_q <= '0;
            mem_indata_q   <= '0;
            mem_controle_q <= 1'b0;
            mem_lerMem_q   <= 1'b0;
            mem_escMem_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            streak_q       <= streak_d;
            count_q        <= count_d;
            if_ready_q     <= if_ready_d;
            if_instr_q     <= if_instr_d;
            if_err_q       <= if_err_d;
            dm_ready_q     <= dm_ready_d;
            dm_rdata_q     <= dm_rdata_d;
            dm_err_q       <= dm_err_d;
            mem_endereco_q <= mem_endereco_d;
            mem_indata_q   <= mem_indata_d;
            mem_controle_q <= mem_controle_d;
            mem_lerMem_q   <= mem_lerMem_d;
            mem_escMem_q   <= mem_escMem_d;
        end
    end

    assign if_ready     = if_ready_q;
    assign if_instr     = if_instr_q;
    assign if_err       = if_err_q;
    assign dm_ready     = dm_ready_q;
    assign dm_rdata     = dm_rdata_q;
    assign dm_err       = dm_err_q;
    assign mem_endereco = mem_endereco_q;
    assign mem_indata   = mem_indata_q;
    assign mem_controle = mem_controle_q;
    assign mem_lerMem   = mem_lerMem_q;
    assign mem_escMem   = mem_escMem_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria: one instance with MEM_LAT=1 and one with MEM_LAT=3,
// each backed by a small two-array memory model.
module tb_arbitro_memoria;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance a: MEM_LAT = 1
    logic        a_if_req, a_if_ready, a_if_err, a_dm_req, a_dm_we, a_dm_ready, a_dm_err;
    logic        a_ctl, a_rd, a_wr;
    logic [31:0] a_if_addr, a_if_instr, a_dm_addr, a_dm_wdata, a_dm_rdata, a_addr, a_indata, a_out;
    logic [31:0] a_imem [512];
    logic [31:0] a_dmem [512];

    // Instance b: MEM_LAT = 3
    logic        b_if_req, b_if_ready, b_if_err, b_dm_req, b_dm_we, b_dm_ready, b_dm_err;
    logic        b_ctl, b_rd, b_wr;
    logic [31:0] b_if_addr, b_if_instr, b_dm_addr, b_dm_wdata, b_dm_rdata, b_addr, b_indata, b_out;
    logic [31:0] b_imem [512];
    logic [31:0] b_dmem [512];

    assign a_out = a_ctl ? a_dmem[a_addr[8:0]] : a_imem[a_addr[8:0]];
    assign b_out = b_ctl ? b_dmem[b_addr[8:0]] : b_imem[b_addr[8:0]];
    always @(posedge clock) if (a_wr && a_ctl) a_dmem[a_addr[8:0]] <= a_indata;
    always @(posedge clock) if (b_wr && b_ctl) b_dmem[b_addr[8:0]] <= b_indata;

    arbitro_memoria #(.MEM_LAT(1), .MAX_STREAK(4)) dut_a (
        .clock(clock), .reset(reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_ready(a_if_ready), .if_instr(a_if_instr), .if_err(a_if_err),
        .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
        .dm_ready(a_dm_ready), .dm_rdata(a_dm_rdata), .dm_err(a_dm_err),
        .mem_endereco(a_addr), .mem_indata(a_indata), .mem_controle(a_ctl),
        .mem_lerMem(a_rd), .mem_escMem(a_wr), .mem_output(a_out)
    );

    arbitro_memoria #(.MEM_LAT(3), .MAX_STREAK(4)) dut_b (
        .clock(clock), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready), .if_instr(b_if_instr), .if_err(b_if_err),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_ready(b_dm_ready), .dm_rdata(b_dm_rdata), .dm_err(b_dm_err),
        .mem_endereco(b_addr), .mem_indata(b_indata), .mem_controle(b_ctl),
        .mem_lerMem(b_rd), .mem_escMem(b_wr), .mem_output(b_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    string exp_order = "DDDDIDDDDI";
    byte   got [10];
    int    n_ev;

    initial begin
        for (int i = 0; i < 512; i++) begin
            a_imem[i] = 32'h0;
            b_imem[i] = 32'h0;
        end
        a_imem[4] = 32'h2002_0005;
        b_imem[4] = 32'h2002_0005;
        for (int i = 0; i < 10; i++) got[i] = 8'h0;

        reset = 1'b1;
        a_if_req = 0; a_if_addr = 0; a_dm_req = 0; a_dm_we = 0; a_dm_addr = 0; a_dm_wdata = 0;
        b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = 0; b_dm_wdata = 0;
        tick();
        tick();
        check("rst_a_if_ready", 32'(a_if_ready), 0);
        check("rst_a_dm_ready", 32'(a_dm_ready), 0);
        check("rst_a_endereco", a_addr, 0);
        check("rst_a_strobes", {29'b0, a_ctl, a_rd, a_wr}, 0);
        check("rst_a_rdata", a_dm_rdata, 0);
        check("rst_b_instr", b_if_instr, 0);
        check("rst_b_strobes", {29'b0, b_ctl, b_rd, b_wr}, 0);
        reset = 1'b0;
        tick();

        // Fetch only, MEM_LAT=1
        a_if_req = 1; a_if_addr = 32'h10;
        tick();
        check("fetch_endereco", a_addr, 4);
        check("fetch_controle", 32'(a_ctl), 0);
        check("fetch_strobes", {30'b0, a_rd, a_wr}, 0);
        check("fetch_early_ready", 32'(a_if_ready), 0);
        tick();
        check("fetch_ready", 32'(a_if_ready), 1);
        check("fetch_instr", a_if_instr, 32'h2002_0005);
        check("fetch_err", 32'(a_if_err), 0);
        check("fetch_mem_idle", {a_addr[28:0], a_ctl, a_rd, a_wr}, 0);
        a_if_req = 0;
        tick();
        check("fetch_ready_pulse", 32'(a_if_ready), 0);
        check("fetch_instr_held", a_if_instr, 32'h2002_0005);

        // Data write then read of 0x20
        a_dm_req = 1; a_dm_we = 1; a_dm_addr = 32'h20; a_dm_wdata = 32'hDEAD_BEEF;
        tick();
        check("wr_escMem", 32'(a_wr), 1);
        check("wr_lerMem", 32'(a_rd), 0);
        check("wr_controle", 32'(a_ctl), 1);
        check("wr_endereco", a_addr, 8);
        check("wr_indata", a_indata, 32'hDEAD_BEEF);
        tick();
        check("wr_ready", 32'(a_dm_ready), 1);
        check("wr_rdata", a_dm_rdata, 0);
        check("wr_escMem_off", 32'(a_wr), 0);
        a_dm_req = 0; a_dm_we = 0;
        tick();
        a_dm_req = 1;
        tick();
        check("rd_lerMem", 32'(a_rd), 1);
        check("rd_escMem", 32'(a_wr), 0);
        check("rd_endereco", a_addr, 8);
        tick();
        check("rd_ready", 32'(a_dm_ready), 1);
        check("rd_rdata", a_dm_rdata, 32'hDEAD_BEEF);
        check("rd_err", 32'(a_dm_err), 0);
        a_dm_req = 0;
        tick();

        // Both requests held, MAX_STREAK=4
        a_if_req = 1; a_if_addr = 32'h10;
        a_dm_req = 1; a_dm_addr = 32'h20; a_dm_we = 0;
        n_ev = 0;
        for (int cyc = 0; cyc < 60 && n_ev < 10; cyc++) begin
            tick();
            check("arb_exclusive", 32'(a_dm_ready & a_if_ready), 0);
            if (a_dm_ready) begin
                got[n_ev] = "D";
                n_ev++;
            end else if (a_if_ready) begin
                got[n_ev] = "I";
                n_ev++;
            end
        end
        check("arb_count", n_ev, 10);
        for (int i = 0; i < 10; i++) check($sformatf("arb_order_%0d", i), 32'(got[i]), 32'(exp_order[i]));
        check("arb_last_instr", a_if_instr, 32'h2002_0005);
        a_if_req = 0; a_dm_req = 0;
        tick();

        // Error paths
        a_dm_req = 1; a_dm_addr = 32'h22; a_dm_we = 0;
        tick();
        check("err_dm_ready", 32'(a_dm_ready), 1);
        check("err_dm_err", 32'(a_dm_err), 1);
        check("err_dm_rdata", a_dm_rdata, 0);
        check("err_dm_nomem", {29'b0, a_ctl, a_rd, a_wr}, 0);
        a_dm_req = 0;
        tick();
        check("err_dm_pulse", 32'(a_dm_ready), 0);
        check("err_dm_err_held", 32'(a_dm_err), 1);
        a_if_req = 1; a_if_addr = 32'h800;
        tick();
        check("err_if_ready", 32'(a_if_ready), 1);
        check("err_if_err", 32'(a_if_err), 1);
        check("err_if_instr", a_if_instr, 0);
        check("err_if_nomem", {29'b0, a_ctl, a_rd, a_wr}, 0);
        a_if_req = 0;
        tick();

        // MEM_LAT=3: write 0xCAFE0001 to 0x40, then timed read
        b_dm_req = 1; b_dm_we = 1; b_dm_addr = 32'h40; b_dm_wdata = 32'hCAFE_0001;
        tick();
        check("l3_wr_escMem", 32'(b_wr), 1);
        check("l3_wr_endereco", b_addr, 16);
        tick();
        tick();
        check("l3_wr_not_ready", 32'(b_dm_ready), 0);
        tick();
        check("l3_wr_ready", 32'(b_dm_ready), 1);
        b_dm_req = 0; b_dm_we = 0;
        tick();
        b_dm_req = 1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("l3_hold_%0d", k), {b_addr[28:0], b_ctl, b_rd, b_wr}, {29'd16, 3'b110});
            check($sformatf("l3_no_ready_%0d", k), 32'(b_dm_ready), 0);
        end
        tick();
        check("l3_ready", 32'(b_dm_ready), 1);
        check("l3_rdata", b_dm_rdata, 32'hCAFE_0001);
        check("l3_mem_idle", {29'b0, b_ctl, b_rd, b_wr}, 0);
        b_dm_req = 0;
        tick();

        // Reset during the 2nd ACCESS cycle abandons the access
        b_dm_req = 1;
        tick();
        tick();
        check("rst_mid_access", 32'(b_rd), 1);
        reset = 1; b_dm_req = 0;
        tick();
        check("rst_mid_ready", 32'(b_dm_ready), 0);
        check("rst_mid_rdata", b_dm_rdata, 0);
        check("rst_mid_mem", {b_addr[28:0], b_ctl, b_rd, b_wr}, 0);
        reset = 0;
        tick();
        check("rst_mid_no_pulse", 32'(b_dm_ready), 0);
        b_if_req = 1; b_if_addr = 32'h10;
        tick();
        tick();
        tick();
        check("post_rst_not_ready", 32'(b_if_ready), 0);
        tick();
        check("post_rst_ready", 32'(b_if_ready), 1);
        check("post_rst_instr", b_if_instr, 32'h2002_0005);
        b_if_req = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
